// File: rtl/adder_pkg.sv
// Shared widths and FSM state encoding for the bit-serial button adder.
package adder_pkg;
    localparam int OPERAND_W = 4;
    localparam int RESULT_W  = 5;
    localparam int COUNT_W   = 3;

    typedef enum logic [1:0] {
        ENT_A = 2'd0,
        ENT_B = 2'd1,
        ADD   = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, and a one-cycle
// pulse on each rising edge of the accepted (debounced) level.
module debounce #(
    parameter int DEBOUNCE_CYCLES = 12000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle where the synchronized input agrees with the level restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;
endmodule

// File: rtl/serial_add_seq.sv
// Two-button entry of two 4-bit operands (MSB first), bit-serial addition
// through one shared full-adder cell, and a registered LED display.
module serial_add_seq
    import adder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 12000
) (
    input  logic CLK,
    input  logic RST,
    input  logic PMOD1,
    input  logic PMOD2,
    output logic LED1,
    output logic LED2,
    output logic LED3,
    output logic LED4,
    output logic LED5
);
    logic press0, press1;

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pmod1 (
        .clk_i   (CLK),
        .rst_i   (RST),
        .btn_i   (PMOD1),
        .press_o (press0)
    );

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pmod2 (
        .clk_i   (CLK),
        .rst_i   (RST),
        .btn_i   (PMOD2),
        .press_o (press1)
    );

    // Simultaneous pulses on both buttons are ambiguous and discarded.
    logic bit_vld, bit_val;
    assign bit_vld = press0 ^ press1;
    assign bit_val = press1;

    state_t                 state_q, state_d;
    logic [COUNT_W-1:0]     cnt_q, cnt_d;
    logic [OPERAND_W-1:0]   a_q, a_d, b_q, b_d;
    logic [RESULT_W-1:0]    s_q, s_d;
    logic                   c_q, c_d;
    logic [RESULT_W-1:0]    led_q, led_d;

    logic [1:0] k;
    logic       fa_a, fa_b, fa_sum, fa_cout;

    assign k       = cnt_q[1:0];
    assign fa_a    = a_q[k];
    assign fa_b    = b_q[k];
    assign fa_sum  = fa_a ^ fa_b ^ c_q;
    assign fa_cout = (fa_a & fa_b) | (fa_a & c_q) | (fa_b & c_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        c_d     = c_q;
        led_d   = '0;

        case (state_q)
            ENT_A: begin
                if (bit_vld) begin
                    a_d = {a_q[OPERAND_W-2:0], bit_val};
                    if (cnt_q == 3'd3) begin
                        state_d = ENT_B;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ENT_B: begin
                if (bit_vld) begin
                    b_d = {b_q[OPERAND_W-2:0], bit_val};
                    if (cnt_q == 3'd3) begin
                        state_d = ADD;
                        cnt_d   = '0;
                        c_d     = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ADD: begin
                s_d[k] = fa_sum;
                c_d    = fa_cout;
                if (cnt_q == 3'd3) begin
                    s_d[OPERAND_W] = fa_cout;
                    state_d        = DONE;
                    cnt_d          = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bit_vld) begin
                    state_d = ENT_A;
                    cnt_d   = '0;
                    a_d     = '0;
                    b_d     = '0;
                    s_d     = '0;
                    c_d     = 1'b0;
                end
            end
            default: state_d = ENT_A;
        endcase

        // Display follows the next state so the registered LEDs change with it.
        case (state_d)
            ENT_A:   led_d = {1'b0, a_d};
            ENT_B:   led_d = {1'b1, b_d};
            DONE:    led_d = s_d;
            default: led_d = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ENT_A;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            c_q     <= c_d;
            led_q   <= led_d;
        end
    end

    assign {LED5, LED4, LED3, LED2, LED1} = led_q;
endmodule

// File: tb/tb_serial_add_seq.sv
// Randomized and directed checks of the button adder against a plain-arithmetic model.
module tb_serial_add_seq;
    logic CLK = 1'b0;
    logic RST, PMOD1, PMOD2;
    logic LED1, LED2, LED3, LED4, LED5;
    logic [4:0] leds;
    logic [4:0] trace [24];
    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;
    assign leds = {LED5, LED4, LED3, LED2, LED1};

    serial_add_seq #(.DEBOUNCE_CYCLES(4)) dut (
        .CLK(CLK), .RST(RST), .PMOD1(PMOD1), .PMOD2(PMOD2),
        .LED1(LED1), .LED2(LED2), .LED3(LED3), .LED4(LED4), .LED5(LED5)
    );

    // Clean press of one or both buttons; trace[i] holds LEDs after edge i+1.
    task automatic press(input logic p1, input logic p2);
        @(negedge CLK);
        PMOD1 = p1;
        PMOD2 = p2;
        for (int i = 0; i < 24; i++) begin
            @(posedge CLK);
            #1;
            trace[i] = leds;
            if (i == 11) begin
                PMOD1 = 1'b0;
                PMOD2 = 1'b0;
            end
        end
    endtask

    task automatic press_bit(input logic b);
        press(~b, b);
    endtask

    task automatic enter(input logic [3:0] a, input logic [3:0] b);
        for (int i = 3; i >= 0; i--) press_bit(a[i]);
        for (int i = 3; i >= 0; i--) press_bit(b[i]);
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RST = 1'b1;
        PMOD1 = 1'b0;
        PMOD2 = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(posedge CLK);
        #1;
        checks++;
        if (leds !== 5'b00000) begin
            failures++;
            $display("FAIL reset_leds: leds=%b expected=%b", leds, 5'b00000);
        end
    endtask

    task automatic test_basic();
        logic [3:0] ma, mb, a, b;
        logic [4:0] exp;
        apply_reset();
        a = 4'b0101;
        b = 4'b0011;
        ma = 0;
        mb = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                press_bit(a[3-i]);
                ma = {ma[2:0], a[3-i]};
                exp = (i == 3) ? {1'b1, 4'b0000} : {1'b0, ma};
            end else begin
                press_bit(b[7-i]);
                mb = {mb[2:0], b[7-i]};
                exp = (i == 7) ? 5'(a + b) : {1'b1, mb};
            end
            checks++;
            if (trace[23] !== exp) begin
                failures++;
                $display("FAIL basic_press%0d: leds=%b expected=%b", i, trace[23], exp);
            end
        end
        repeat (20) @(posedge CLK);
        #1;
        checks++;
        if (leds !== 5'b01000) begin
            failures++;
            $display("FAIL basic_hold: leds=%b expected=%b", leds, 5'b01000);
        end
    endtask

    task automatic test_add_window();
        int zeros;
        apply_reset();
        enter(4'b1111, 4'b0001);
        zeros = 0;
        for (int i = 0; i < 24; i++) if (trace[i] == 5'b00000) zeros++;
        checks++;
        if (zeros != 4) begin
            failures++;
            $display("FAIL add_zero_cycles: count=%0d expected=4", zeros);
        end
        checks++;
        if (trace[5] !== 5'b10000 || trace[6] !== 5'b00000) begin
            failures++;
            $display("FAIL add_start: t5=%b t6=%b expected=10000/00000", trace[5], trace[6]);
        end
        checks++;
        if (trace[10] !== 5'b10000 || trace[23] !== 5'b10000) begin
            failures++;
            $display("FAIL add_result: t10=%b t23=%b expected=10000", trace[10], trace[23]);
        end
    endtask

    task automatic test_done_press();
        apply_reset();
        for (int i = 3; i >= 0; i--) press_bit(1'(4'b0011 >> i));
        for (int i = 3; i >= 1; i--) press_bit(1'(4'b0101 >> i));
        // Last bit on PMOD2; PMOD1 rises 2 cycles later so its pulse lands in ADD.
        @(negedge CLK);
        PMOD2 = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(posedge CLK);
            #1;
            trace[i] = leds;
            if (i == 1) PMOD1 = 1'b1;
            if (i == 13) begin
                PMOD1 = 1'b0;
                PMOD2 = 1'b0;
            end
        end
        checks++;
        if (trace[10] !== 5'b01000 || trace[23] !== 5'b01000) begin
            failures++;
            $display("FAIL add_ignores_press: t10=%b t23=%b expected=01000", trace[10], trace[23]);
        end
        press_bit(1'b1);
        checks++;
        if (trace[23] !== 5'b00000) begin
            failures++;
            $display("FAIL done_clear: leds=%b expected=00000", trace[23]);
        end
        press_bit(1'b1);
        checks++;
        if (trace[23] !== 5'b00001) begin
            failures++;
            $display("FAIL done_no_bit: leds=%b expected=00001", trace[23]);
        end
    endtask

    task automatic test_glitch();
        logic bounce [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        apply_reset();
        @(negedge CLK);
        PMOD2 = 1'b1;
        repeat (3) @(negedge CLK);
        PMOD2 = 1'b0;
        repeat (12) @(negedge CLK);
        checks++;
        if (leds !== 5'b00000) begin
            failures++;
            $display("FAIL glitch_ignored: leds=%b expected=00000", leds);
        end
        for (int i = 0; i < 6; i++) begin
            PMOD2 = bounce[i];
            @(negedge CLK);
        end
        PMOD2 = 1'b1;
        repeat (12) @(negedge CLK);
        PMOD2 = 1'b0;
        repeat (12) @(negedge CLK);
        checks++;
        if (leds !== 5'b00001) begin
            failures++;
            $display("FAIL bounce_one_bit: leds=%b expected=00001", leds);
        end
        press_bit(1'b0);
        press_bit(1'b0);
        checks++;
        if (trace[23] !== 5'b00100) begin
            failures++;
            $display("FAIL glitch_count3: leds=%b expected=00100", trace[23]);
        end
        press_bit(1'b0);
        checks++;
        if (trace[23] !== 5'b10000) begin
            failures++;
            $display("FAIL glitch_count4: leds=%b expected=10000", trace[23]);
        end
    endtask

    task automatic test_simul();
        apply_reset();
        for (int i = 3; i >= 0; i--) press_bit(1'(4'b0110 >> i));
        press_bit(1'b1);
        press_bit(1'b1);
        press(1'b1, 1'b1);
        checks++;
        if (trace[23] !== 5'b10011) begin
            failures++;
            $display("FAIL simul_ignored: leds=%b expected=10011", trace[23]);
        end
        press_bit(1'b0);
        checks++;
        if (trace[23] !== 5'b10110) begin
            failures++;
            $display("FAIL simul_then_single: leds=%b expected=10110", trace[23]);
        end
        press_bit(1'b1);
        checks++;
        if (trace[23] !== 5'(4'd6 + 4'd13)) begin
            failures++;
            $display("FAIL simul_sum: leds=%b expected=%b", trace[23], 5'(4'd6 + 4'd13));
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 3; i >= 0; i--) press_bit(1'(4'b1010 >> i));
        press_bit(1'b1);
        press_bit(1'b1);
        checks++;
        if (trace[23] !== 5'b10011) begin
            failures++;
            $display("FAIL midreset_pre: leds=%b expected=10011", trace[23]);
        end
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (leds !== 5'b00000) begin
            failures++;
            $display("FAIL midreset_leds: leds=%b expected=00000", leds);
        end
        @(negedge CLK);
        RST = 1'b0;
        press_bit(1'b1);
        checks++;
        if (trace[23] !== 5'b00001) begin
            failures++;
            $display("FAIL midreset_enta: leds=%b expected=00001", trace[23]);
        end
        for (int i = 2; i >= 0; i--) press_bit(1'b0);
        for (int i = 3; i >= 0; i--) press_bit(1'(4'b1000 >> i));
        checks++;
        if (trace[23] !== 5'b10000) begin
            failures++;
            $display("FAIL midreset_sum: leds=%b expected=10000", trace[23]);
        end
    endtask

    task automatic test_random();
        logic [3:0] a, b;
        logic [4:0] exp;
        for (int n = 0; n < 5; n++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            exp = 5'(int'(a) + int'(b));
            apply_reset();
            enter(a, b);
            checks++;
            if (trace[23] !== exp) begin
                failures++;
                $display("FAIL random_sum%0d: a=%0d b=%0d leds=%b expected=%b", n, a, b, trace[23], exp);
            end
        end
    endtask

    initial begin
        RST = 1'b1;
        PMOD1 = 1'b0;
        PMOD2 = 1'b0;
        test_reset();
        test_basic();
        test_add_window();
        test_done_press();
        test_glitch();
        test_simul();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_add_seq.md
SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 12000, which is the number of consecutive stable cycles needed to accept a button level (1 ms at 12 MHz).
REQ-002 The module SHALL have port CLK, input, width 1: the single system clock; all logic is on its rising edge.
REQ-003 The module SHALL have port RST, input, width 1: synchronous, active-high reset.
REQ-004 The module SHALL have port PMOD1, input, width 1: raw active-high button that enters bit value 0.
REQ-005 The module SHALL have port PMOD2, input, width 1: raw active-high button that enters bit value 1.
REQ-006 The module SHALL have ports LED1..LED4, output, width 1 each: a display nibble, LED1 = bit 0.
REQ-007 The module SHALL have port LED5, output, width 1: the phase flag during entry and the carry/sum bit 4 when the result is shown.
REQ-008 The design SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-009 Each PMOD input SHALL pass through a 2-FF synchronizer, then a debouncer.
REQ-010 The debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-011 A press SHALL be a one-cycle pulse on the 0->1 edge of the debounced level.
REQ-012 The FSM SHALL have states ENT_A, ENT_B, ADD and DONE, and a 3-bit bit counter.
REQ-013 In ENT_A, a press SHALL shift a bit into register A, MSB first: A <= {A[2:0], bit}.
REQ-014 In ENT_A, the count SHALL increment on each press; on the 4th press the FSM SHALL go to ENT_B with count 0.
REQ-015 In ENT_B, presses SHALL shift into register B in the same way; on the 4th press the FSM SHALL go to ADD with count 0 and carry 0.
REQ-016 ADD SHALL be bit-serial, LSB first, with one shared 1-bit full-adder cell.
REQ-017 In ADD cycle k (k = 0..3), S[k] SHALL take A[k]^B[k]^c and c SHALL take maj(A[k], B[k], c).
REQ-018 After cycle k = 3, S[4] SHALL take the final carry and the FSM SHALL go to DONE.
REQ-019 Latency SHALL be: 8th accepted press at cycle N, ADD during N+1..N+4, DONE visible at N+5.
REQ-020 Arithmetic SHALL be unsigned, S = A + B with a 5-bit result and no overflow loss.
REQ-021 In ENT_A, LED1..4 SHALL show A[0..3] and LED5 SHALL be 0.
REQ-022 In ENT_B, LED1..4 SHALL show B[0..3] and LED5 SHALL be 1.
REQ-023 In ADD, all LEDs SHALL be 0.
REQ-024 In DONE, LED1..LED5 SHALL show S[0..4].
REQ-025 In DONE, a press SHALL clear A, B, S and the count and go to ENT_A; that press SHALL NOT be entered as a bit.
REQ-026 Presses during ADD SHALL be ignored.
REQ-027 Press pulses on PMOD1 and PMOD2 in the same cycle SHALL both be ignored in every state.
REQ-028 A button held down SHALL produce exactly one press.
REQ-029 All LED outputs SHALL be registered.

Reset
REQ-030 While RST is high at a clock edge, the block SHALL set: state ENT_A; count 0; A, B, S and carry 0; all LEDs 0.
REQ-031 The same reset SHALL return the synchronizers and debounced levels to 0 and clear the debounce counters.
REQ-032 A reset during entry or ADD SHALL abandon the operation, and no partial result SHALL ever be displayed.
REQ-033 The first press after reset SHALL need a full debounce interval measured from release of reset.

Structure
REQ-034 Shared package adder_pkg SHALL hold OPERAND_W = 4, RESULT_W = 5 and the FSM state encoding.
REQ-035 Sub-module debounce (synchronizer, counter, edge pulse; parameter DEBOUNCE_CYCLES) SHALL be instantiated once per PMOD input.
REQ-036 The full-adder cell, FSM, operand registers and LED muxing SHALL be inline in serial_add_seq.

Verification (bench uses DEBOUNCE_CYCLES = 4, clean presses unless noted)
REQ-037 Enter A = 0101, B = 0011, which is 8 presses -> 5 cycles later LED5..1 = 01000, held until the next press.
REQ-038 Enter A = 1111, B = 0001 -> LED5..1 = 10000; during ADD all LEDs are 0 for exactly 4 cycles.
REQ-039 A PMOD2 glitch high for 3 cycles, then a bouncing press that settles high -> no bit for the glitch, exactly one '1' for the settled press; during ENT_A, LED1 = 1 and count = 1.
REQ-040 Press PMOD1 and PMOD2 in the same cycle during ENT_B -> B and count unchanged; then a single PMOD1 press is accepted normally.
REQ-041 Assert RST for 1 cycle after 6 presses -> next cycle all LEDs 0 and state ENT_A; a following full 8-press sequence A = 1000, B = 1000 -> LED5..1 = 10000.
REQ-042 In DONE, press PMOD2 -> state ENT_A, all LEDs 0, no bit entered; presses during ADD have no effect on S.
